// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and defaults for the sequence-detector run controller.
package seq_ctrl_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Length 0 behaves as 1; anything beyond the register width behaves as the full width.
  function automatic int unsigned clamp_len(int unsigned len, int unsigned max_len);
    if (len == 0)
      return 1;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host-side bundle: config handshake, run control, serial stream and status.
interface seq_detect_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) ();

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_overlap;
  logic               start;
  logic               abort;
  logic               x;
  logic               x_valid;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
           start, abort, x, x_valid,
    input  cfg_ready, z, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
           start, abort, x, x_valid,
    output cfg_ready, z, match_count, busy, done
  );

endinterface

// File: rtl/seq_match_core.sv
// Shift register, fill counter and length-masked pattern compare.
module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               clear,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] sr_q, sr_nxt, mask;
  logic [LEN_W-1:0]   fill_q, fill_inc;

  // Next shift/fill values and compare against the low len bits of the pattern.
  always_comb begin
    sr_nxt   = {sr_q[MAX_LEN-2:0], x};
    fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + LEN_W'(1);
    mask     = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      mask[i] = (i < 32'(len));
    hit = step && (fill_inc >= len) && (((sr_nxt ^ pattern) & mask) == '0);
  end

  // Core state only moves on qualified bits; a non-overlapping match drops the fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else if (clear) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else if (step) begin
      sr_q   <= sr_nxt;
      fill_q <= (hit && !overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config latch, IDLE/READY/RUN/DONE sequencing, match counting.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic              clk,
  input logic              reset,
  seq_detect_ctrl_if.slave bus
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic               z_q;
  logic               cfg_ready, busy, done;
  logic               cfg_acc, go, step, hit, final_hit;

  assign cfg_acc   = bus.cfg_valid && cfg_ready && !bus.abort;
  assign go        = bus.start && (state_q == READY || state_q == DONE) && !bus.abort;
  assign step      = (state_q == RUN) && bus.x_valid;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign final_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .clear   (go),
    .x       (bus.x),
    .pattern (pat_q),
    .len     (len_q),
    .overlap (ovl_q),
    .hit     (hit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_acc) state_d = READY;
      READY:   if (bus.start) state_d = RUN;
      RUN:     if (final_hit) state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
               else if (cfg_acc) state_d = READY;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // State-decoded status outputs.
  always_comb begin
    cfg_ready = (state_q != RUN);
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
  end

  // Config registers; retained across abort, overwritten only by a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= LEN_W'(1);
      tgt_q <= '0;
      ovl_q <= 1'b0;
    end else if (cfg_acc) begin
      pat_q <= bus.cfg_pattern;
      len_q <= LEN_W'(clamp_len(32'(bus.cfg_len), unsigned'(MAX_LEN)));
      tgt_q <= bus.cfg_target;
      ovl_q <= bus.cfg_overlap;
    end
  end

  // Match pulse and saturating counter; abort suppresses a same-cycle match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      z_q <= hit && !bus.abort;
      if (bus.abort || go)
        cnt_q <= '0;
      else if (hit)
        cnt_q <= cnt_inc;
    end
  end

  assign bus.cfg_ready   = cfg_ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.z           = z_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: table of full runs plus corner sequences.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  seq_detect_ctrl_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus ();

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic [7:0]  tgt;
    int          gap;
    int          nbits;
    logic [15:0] stream;  // bit i = i-th bit sent
    logic [15:0] exp_z;   // bit i = z expected after bit i
    int          exp_cnt;
    logic        exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    bus.cfg_target  = t;
    bus.cfg_valid   = 1'b1;
    tick();
    bus.cfg_valid   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic exp_z, input string name);
    bus.x       = b;
    bus.x_valid = 1'b1;
    tick();
    bus.x_valid = 1'b0;
    check(name, bus.z, exp_z);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    pulse_abort();
    do_cfg(v.pat, v.len, v.ovl, v.tgt);
    pulse_start();
    check($sformatf("v%0d_busy_start", k), bus.busy, 1);
    check($sformatf("v%0d_cnt_start", k), bus.match_count, 0);
    for (int i = 0; i < v.nbits; i++) begin
      send_bit(v.stream[i], v.exp_z[i], $sformatf("v%0d_z_bit%0d", k, i));
      for (int g = 0; g < v.gap; g++) begin
        tick();
        check($sformatf("v%0d_z_gap%0d", k, i), bus.z, 0);
      end
    end
    check($sformatf("v%0d_count", k), bus.match_count, v.exp_cnt);
    check($sformatf("v%0d_done", k), bus.done, v.exp_done);
    check($sformatf("v%0d_busy_end", k), bus.busy, !v.exp_done);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // pattern 0110, stream 0,0,1,1,0,1,1,0,0,1,1,0
    vecs[0] = '{8'h06, 4'd4, 1'b1, 8'd0, 0, 12, 16'h066C, 16'h0890, 3, 1'b0};
    vecs[1] = '{8'h06, 4'd4, 1'b0, 8'd0, 0, 12, 16'h066C, 16'h0810, 2, 1'b0};
    vecs[2] = '{8'h06, 4'd4, 1'b1, 8'd2, 0, 12, 16'h066C, 16'h0090, 2, 1'b1};
    vecs[3] = '{8'h06, 4'd4, 1'b1, 8'd0, 3, 12, 16'h066C, 16'h0890, 3, 1'b0};
    // len 0 acts as 1: every '1' matches; target 3 stops before the last bit
    vecs[4] = '{8'h01, 4'd0, 1'b1, 8'd3, 0, 5,  16'h001D, 16'h000D, 3, 1'b1};
    // len 15 clamps to 8: full-byte pattern A5
    vecs[5] = '{8'hA5, 4'd15, 1'b1, 8'd0, 0, 9, 16'h00A5, 16'h0080, 1, 1'b0};

    bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0;
    bus.cfg_overlap = 0; bus.start = 0; bus.abort = 0; bus.x = 0; bus.x_valid = 0;

    #12;
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_z", bus.z, 0);
    check("rst_count", bus.match_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // start in IDLE is ignored
    pulse_start();
    check("idle_start_busy", bus.busy, 0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // abort in the same cycle a match completes
    pulse_abort();
    do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send_bit(0, 0, "ab_b0"); send_bit(0, 0, "ab_b1");
    send_bit(1, 0, "ab_b2"); send_bit(1, 0, "ab_b3");
    bus.abort = 1'b1;
    send_bit(0, 0, "ab_z_suppressed");
    bus.abort = 1'b0;
    check("ab_count", bus.match_count, 0);
    check("ab_busy", bus.busy, 0);
    check("ab_cfg_ready", bus.cfg_ready, 1);
    pulse_start();
    check("ab_idle_start_busy", bus.busy, 0);

    // asynchronous reset right after a match pulse
    do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send_bit(0, 0, "rr_b0"); send_bit(0, 0, "rr_b1");
    send_bit(1, 0, "rr_b2"); send_bit(1, 0, "rr_b3");
    send_bit(0, 1, "rr_b4");
    check("rr_count_pre", bus.match_count, 1);
    #2 reset = 1'b1;
    #1;
    check("rr_z", bus.z, 0);
    check("rr_count", bus.match_count, 0);
    check("rr_busy", bus.busy, 0);
    check("rr_cfg_ready", bus.cfg_ready, 1);
    check("rr_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rr_no_pending_z", bus.z, 0);
    pulse_start();
    check("rr_idle_start_busy", bus.busy, 0);
    do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
    pulse_start();
    check("rr_busy_after_cfg", bus.busy, 1);
    send_bit(0, 0, "rr2_b0"); send_bit(1, 0, "rr2_b1");
    send_bit(1, 0, "rr2_b2"); send_bit(0, 1, "rr2_b3");
    check("rr2_count", bus.match_count, 1);

    // DONE, then config and start together: new config used; config ignored in RUN
    pulse_abort();
    do_cfg(8'h06, 4'd4, 1'b1, 8'd1);
    pulse_start();
    send_bit(0, 0, "cs_b0"); send_bit(1, 0, "cs_b1");
    send_bit(1, 0, "cs_b2"); send_bit(0, 1, "cs_b3");
    check("cs_done", bus.done, 1);
    bus.cfg_pattern = 8'h09; bus.cfg_len = 4'd4; bus.cfg_overlap = 1'b1; bus.cfg_target = 8'd0;
    bus.cfg_valid = 1'b1; bus.start = 1'b1;
    tick();
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    check("cs_busy", bus.busy, 1);
    check("cs_cfg_ready_run", bus.cfg_ready, 0);
    bus.cfg_pattern = 8'h06; bus.cfg_valid = 1'b1;
    send_bit(1, 0, "cs2_b0"); send_bit(0, 0, "cs2_b1");
    send_bit(0, 0, "cs2_b2"); send_bit(1, 1, "cs2_b3");
    send_bit(0, 0, "cs2_b4"); send_bit(0, 0, "cs2_b5");
    send_bit(1, 1, "cs2_b6");
    bus.cfg_valid = 1'b0;
    check("cs2_count", bus.match_count, 2);
    check("cs2_busy", bus.busy, 1);

    // counter saturation with a 1-bit pattern matching every bit
    pulse_abort();
    do_cfg(8'h01, 4'd1, 1'b1, 8'd0);
    pulse_start();
    bus.x = 1'b1; bus.x_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    check("sat_z", bus.z, 1);
    bus.x_valid = 1'b0;
    tick();
    check("sat_count", bus.match_count, 255);
    check("sat_busy", bus.busy, 1);
    check("sat_z_idle", bus.z, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
